// File: rtl/snes_poll_ctrl.sv
// SNES pad poller: drives latch/serial clock, shifts in 16 active-low bits, presents an active-high word.
// Optional SNES_DEBOUNCE_EN: the word only updates when two consecutive polls read back identical.
module snes_poll_ctrl #(
  parameter int LATCH_CYC   = 600,
  parameter int HALF_CYC    = 300,
  parameter int POLL_PERIOD = 833333
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        poll_req,
  input  logic        auto_en,
  output logic        snes_latch,
  output logic        snes_clk,
  input  logic        snes_data,
  output logic [15:0] buttons,
  output logic        valid,
  output logic        busy
);

  localparam int PHASE_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
  localparam int PW        = $clog2(PHASE_MAX);
  localparam int TW        = $clog2(POLL_PERIOD);

  localparam logic [PW-1:0] LATCH_LAST = PW'(LATCH_CYC - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_CYC - 1);
  localparam logic [TW-1:0] TIMER_TOP  = TW'(POLL_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] phase;
  logic [3:0]    index;
  logic [TW-1:0] timer;
  logic [15:0]   shift;
  logic [1:0]    sync;
  logic          data_s;
  logic          auto_trig;
  logic          trigger;
  logic          phase_last;
  logic          shift_en;
  logic          done_load;

`ifdef SNES_DEBOUNCE_EN
  logic [15:0]   prev_raw;
`endif

  assign data_s    = sync[1];
  assign auto_trig = auto_en && (timer == TIMER_TOP);
  assign trigger   = poll_req || auto_trig;
  assign busy      = (state != S_IDLE);

  always_comb begin
    phase_last = 1'b0;
    if (state == S_LATCH) begin
      phase_last = (phase == LATCH_LAST);
    end else if (state == S_LOW || state == S_HIGH) begin
      phase_last = (phase == HALF_LAST);
    end
  end

  // The sample point is the end of the low phase, well after the pad shifted on the previous rise.
  assign shift_en  = (state == S_LOW) && phase_last;
  assign done_load = (state == S_HIGH) && phase_last && (index == 4'd15);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (trigger)    state_next = S_LATCH;
      S_LATCH: if (phase_last) state_next = S_LOW;
      S_LOW:   if (phase_last) state_next = S_HIGH;
      S_HIGH: begin
        if (phase_last) state_next = (index == 4'd15) ? S_DONE : S_LOW;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      phase <= '0;
    end else begin
      state <= state_next;
      if (state_next != state || state == S_IDLE) begin
        phase <= '0;
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index <= 4'd0;
    end else if (state == S_LATCH) begin
      index <= 4'd0;
    end else if (state == S_HIGH && phase_last) begin
      index <= index + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (!auto_en || timer == TIMER_TOP) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= 2'b11;
      shift <= 16'h0000;
    end else begin
      sync <= {sync[0], snes_data};
      if (shift_en) begin
        shift <= {~data_s, shift[15:1]};
      end
    end
  end

  // Pad pins are registered from the next state so they are glitch-free and line up with the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snes_latch <= 1'b0;
      snes_clk   <= 1'b1;
    end else begin
      snes_latch <= (state_next == S_LATCH);
      snes_clk   <= (state_next != S_LOW);
    end
  end

  // Loaded on the last high cycle so buttons and valid are both visible during DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buttons  <= 16'h0000;
      valid    <= 1'b0;
`ifdef SNES_DEBOUNCE_EN
      prev_raw <= 16'h0000;
`endif
    end else begin
      valid <= 1'b0;
      if (done_load) begin
`ifdef SNES_DEBOUNCE_EN
        prev_raw <= shift;
        if (shift == prev_raw) begin
          buttons <= shift;
          valid   <= 1'b1;
        end
`else
        buttons <= shift;
        valid   <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_snes_poll_ctrl.sv
// Bench for snes_poll_ctrl: pad model, table-driven polls, scoreboard queue of expected button words.
module tb_snes_poll_ctrl;

  localparam int LATCH_CYC   = 4;
  localparam int HALF_CYC    = 4;
  localparam int POLL_PERIOD = 200;
  localparam int LAT         = LATCH_CYC + 32 * HALF_CYC + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        poll_req = 1'b0;
  logic        auto_en = 1'b0;
  logic        snes_data = 1'b1;
  logic        snes_latch;
  logic        snes_clk;
  logic [15:0] buttons;
  logic        valid;
  logic        busy;

  snes_poll_ctrl #(
    .LATCH_CYC(LATCH_CYC),
    .HALF_CYC(HALF_CYC),
    .POLL_PERIOD(POLL_PERIOD)
  ) dut (
    .clk(clk),
    .reset(rst),
    .poll_req(poll_req),
    .auto_en(auto_en),
    .snes_latch(snes_latch),
    .snes_clk(snes_clk),
    .snes_data(snes_data),
    .buttons(buttons),
    .valid(valid),
    .busy(busy)
  );

  // clock / reset / cycle count
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pad model: loads on latch, presents bit 0, shifts on each rising snes_clk
  logic [15:0] pad_raw = 16'hFFFF;
  int          pad_pos = 0;
  always @(posedge snes_latch or posedge snes_clk) begin
    if (snes_latch) begin
      pad_pos   = 0;
      snes_data = pad_raw[0];
    end else begin
      pad_pos   = pad_pos + 1;
      snes_data = (pad_pos < 16) ? pad_raw[pad_pos[3:0]] : 1'b1;
    end
  end

  int fall_cnt = 0;
  int rise_cnt = 0;
  int latch_cnt = 0;
  int overlap_cnt = 0;
  always @(negedge snes_clk) fall_cnt <= fall_cnt + 1;
  always @(posedge snes_clk) rise_cnt <= rise_cnt + 1;
  always @(negedge clk) begin
    if (snes_latch) latch_cnt <= latch_cnt + 1;
    if (snes_latch && !snes_clk) overlap_cnt <= overlap_cnt + 1;
  end

  // scoreboard
  logic [15:0] exp_q[$];
  int          cyc_q[$];
  logic [15:0] m_prev = 16'h0000;
  logic [15:0] m_buttons = 16'h0000;
  logic [15:0] mon_e;
  int          mon_c;
  int          n_checks = 0;
  int          n_pass = 0;
  int          trig_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  task automatic push_expect(input logic [15:0] raw, input logic [15:0] expb, input int vcyc);
`ifdef SNES_DEBOUNCE_EN
    if (raw == m_prev) begin
      exp_q.push_back(expb);
      cyc_q.push_back(vcyc);
      m_buttons = expb;
    end
    m_prev = raw;
`else
    exp_q.push_back(expb);
    cyc_q.push_back(vcyc);
    m_buttons = expb;
    m_prev = raw;
`endif
  endtask

  task automatic model_reset();
    exp_q.delete();
    cyc_q.delete();
    m_prev = 16'h0000;
    m_buttons = 16'h0000;
  endtask

  // driver tasks; all assume the caller sits just after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_poll(input logic [15:0] raw, input logic [15:0] expb);
    pad_raw  = raw;
    poll_req = 1'b1;
    trig_cyc = cyc;
    push_expect(raw, expb, trig_cyc + LAT);
    tick(1);
    poll_req = 1'b0;
    check("busy_after_trigger", {31'd0, busy}, 32'd1);
  endtask

  task automatic finish_poll();
    int n;
    n = 0;
    while (busy && n < 2 * LAT) begin
      tick(1);
      n++;
    end
    check("poll_completes", {31'd0, busy}, 32'd0);
    tick(2);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  typedef struct {
    logic [15:0] raw;
    logic [15:0] expb;
  } vec_t;

  vec_t vecs[7];
  int   f0, r0, l0;
  int   a0;
  int   c0;

  initial begin
    vecs[0] = '{16'hFFF6, 16'h0009};
    vecs[1] = '{16'hFEFF, 16'h0100};
    vecs[2] = '{16'hFFFF, 16'h0000};
    vecs[3] = '{16'h0000, 16'hFFFF};
    vecs[4] = '{16'h5A5A, 16'hA5A5};
    vecs[5] = '{16'h7FFE, 16'h8001};
    vecs[6].raw  = 16'($urandom_range(0, 65535));
    vecs[6].expb = ~vecs[6].raw;

    fork
      forever begin
        @(negedge clk);
        if (!rst && valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", {31'd0, valid}, 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            mon_c = cyc_q.pop_front();
            check("buttons", {16'd0, buttons}, {16'd0, mon_e});
            check("valid_cycle", cyc, mon_c);
            check("busy_at_valid", {31'd0, busy}, 32'd1);
          end
        end
      end
    join_none

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_latch", {31'd0, snes_latch}, 32'd0);
    check("rst_clk", {31'd0, snes_clk}, 32'd1);
    check("rst_buttons", {16'd0, buttons}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(2);

    // asynchronous reset in the middle of a cycle
    start_poll(16'hFFF6, 16'h0009);
    tick(1);
    check("latch_before_async", {31'd0, snes_latch}, 32'd1);
    @(negedge clk);
    c0 = cyc;
    rst = 1'b1;
    #1;
    check("async_latch", {31'd0, snes_latch}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_no_edge", cyc, c0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    tick(3);

    // latch window T+1..T+4, first low phase at T+5
    check("latch_at_T", {31'd0, snes_latch}, 32'd0);
    f0 = fall_cnt; r0 = rise_cnt; l0 = latch_cnt;
    start_poll(16'hFFF6, 16'h0009);
    check("latch_at_T1", {31'd0, snes_latch}, 32'd1);
    tick(3);
    check("latch_at_T4", {31'd0, snes_latch}, 32'd1);
    tick(1);
    check("latch_at_T5", {31'd0, snes_latch}, 32'd0);
    check("clk_low_at_T5", {31'd0, snes_clk}, 32'd0);
    finish_poll();
    check("falls_first", fall_cnt - f0, 32'd16);
    check("rises_first", rise_cnt - r0, 32'd16);
    check("latch_cycles_first", latch_cnt - l0, LATCH_CYC);

    // table-driven polls, each vector twice
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 2; k++) begin
        f0 = fall_cnt; r0 = rise_cnt; l0 = latch_cnt;
        start_poll(vecs[i].raw, vecs[i].expb);
        finish_poll();
        check("falls", fall_cnt - f0, 32'd16);
        check("rises", rise_cnt - r0, 32'd16);
        check("latch_cycles", latch_cnt - l0, LATCH_CYC);
      end
    end

    // a second request during a poll is dropped
    start_poll(16'hFFF6, 16'h0009);
    a0 = trig_cyc;
    tick(a0 + 50 - cyc);
    poll_req = 1'b1;
    tick(1);
    poll_req = 1'b0;
    tick(a0 + 300 - cyc);
    check("single_valid_drain", exp_q.size(), 32'd0);
    check("buttons_hold", {16'd0, buttons}, {16'd0, m_buttons});

    // free-running auto poll
    pad_raw = 16'hFEFF;
    auto_en = 1'b1;
    a0 = cyc;
    push_expect(16'hFEFF, 16'h0100, a0 + POLL_PERIOD - 1 + LAT);
    push_expect(16'hFEFF, 16'h0100, a0 + 2 * POLL_PERIOD - 1 + LAT);
    tick(2 * POLL_PERIOD + LAT + 1);
    auto_en = 1'b0;
    check("auto_drain", exp_q.size(), 32'd0);
    tick(300);
    check("auto_off_busy", {31'd0, busy}, 32'd0);

    // reset during the fifth low phase aborts the poll
    start_poll(16'hFFF6, 16'h0009);
    tick(trig_cyc + 38 - cyc);
    check("clk_low_phase5", {31'd0, snes_clk}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_clk", {31'd0, snes_clk}, 32'd1);
    check("abort_buttons", {16'd0, buttons}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    tick(300);
    check("abort_no_restart", {31'd0, busy}, 32'd0);

    // debounce sequence (every poll reports when the filter is compiled out)
    start_poll(16'hFFFE, 16'h0001);
    finish_poll();
    start_poll(16'hFFFD, 16'h0002);
    finish_poll();
    start_poll(16'hFFFD, 16'h0002);
    finish_poll();
    check("debounce_buttons", {16'd0, buttons}, {16'd0, m_buttons});

    check("latch_clk_overlap", overlap_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/snes_poll_ctrl.md
Name: snes_poll_ctrl

Overview:
Console-side SNES controller poller. It generates the latch and serial-clock waveform that a SNES pad, or our pad emulator, expects. It shifts in 16 serial bits and presents them as an active-high button word with a one-cycle valid strobe. It sits between the pad connector pins and the game/UI logic, and polls on request or from a free-running frame timer.

Parameters:
LATCH_CYC, 600, cycles snes_latch is held high (12 us at 50 MHz); minimum 2
HALF_CYC, 300, cycles per snes_clk half-period (6 us at 50 MHz); minimum 4
POLL_PERIOD, 833333, auto-poll interval in cycles (60 Hz at 50 MHz); must exceed LATCH_CYC+32*HALF_CYC+2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active high
poll_req  in  1  single-cycle request to start one poll
auto_en  in  1  enables periodic polling from internal timer
snes_latch  out  1  latch pulse to pad, active high
snes_clk  out  1  serial clock to pad; idles high
snes_data  in  1  serial data from pad; active low (0 = pressed)
buttons  out  16  active-high button word: 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R, 15:12 ID bits
valid  out  1  one-cycle pulse when buttons is updated
busy  out  1  high from trigger acceptance until the DONE cycle inclusive

Behaviour:
- Reset (async, active high) forces the following immediately: state IDLE, snes_latch=0, snes_clk=1, buttons=0, valid=0, busy=0, bit index=0, timer=0, shift register=0, synchroniser flops=1.
- snes_data passes through a 2-flop synchroniser before sampling.
- Timer
  - Counts 0..POLL_PERIOD-1 and wraps while auto_en=1.
  - Held at 0 while auto_en=0.
  - Auto trigger fires on the wrap cycle.
- FSM states: IDLE, LATCH, LOW, HIGH, DONE.
- IDLE
  - Moves to LATCH when poll_req=1 or an auto trigger fires.
  - Simultaneous poll_req and auto trigger produce one poll.
  - Triggers arriving outside IDLE are dropped, not queued.
- LATCH: snes_latch=1 for exactly LATCH_CYC cycles, then moves to LOW with index=0.
- LOW
  - snes_clk=0 for HALF_CYC cycles.
  - On the last LOW cycle, the inverted synchronised data shifts into the shift register MSB-in, shift-right, so the first bit lands in buttons[0].
- HIGH
  - snes_clk=1 for HALF_CYC cycles; the pad shifts on this rising edge.
  - If index==15, moves to DONE; otherwise index+1 and back to LOW.
- DONE (one cycle): buttons<=shift register, valid=1, busy=1, then IDLE.
- Exactly 16 falling and 16 rising snes_clk edges per poll. snes_clk never toggles during LATCH.
- Latency: valid is asserted exactly LATCH_CYC+32*HALF_CYC+1 cycles after the trigger cycle.
- buttons holds its value between polls.
- Phase counter width is $clog2 of the larger of LATCH_CYC and HALF_CYC. Timer width is $clog2(POLL_PERIOD).
- Reset mid-poll aborts the poll: no valid is issued, and the next poll needs a fresh trigger.

Optional Feature:
SNES_DEBOUNCE_EN
- Defined:
  - A 16-bit prev_raw register (reset 0) holds the previous completed poll.
  - In DONE, buttons updates only if the shift register equals prev_raw; prev_raw<=shift register every DONE.
  - valid pulses only when buttons is written.
- Undefined: buttons updates and valid pulses on every DONE, as above.

Test Plan:
All scenarios use LATCH_CYC=4, HALF_CYC=4, POLL_PERIOD=200.
1. Assert reset 3 cycles -> snes_latch=0, snes_clk=1, buttons=16'h0000, valid=0, busy=0. Assert reset asynchronously mid-cycle -> outputs change before the next clk edge.
2. Pad model drives raw 16'hFFF6 (B and Start pressed), shifting on each snes_clk rising edge; pulse poll_req at cycle T -> snes_latch high T+1..T+4; 16 snes_clk falls; valid single pulse at T+133; buttons=16'h0009.
3. Same poll; pulse poll_req again at T+50 -> ignored; exactly one valid pulse within 300 cycles.
4. auto_en=1, pad raw 16'hFEFF (A pressed) -> valid pulses exactly 200 cycles apart; buttons=16'h0100. auto_en=0 -> no further pulses.
5. poll_req, then assert reset during the 5th LOW phase -> snes_clk=1 and buttons=0 at once; no valid for 300 cycles after release without a new trigger.
6. With SNES_DEBOUNCE_EN defined: polls with raw 16'hFFFE, 16'hFFFD, 16'hFFFD -> no valid on the first two; third poll gives valid and buttons=16'h0002.
